// File: rtl/core_dmem_responder.sv
// Single-ported data memory responder: one outstanding request, fixed LATENCY
// from accept to response, byte-lane stores, range/alignment fault reporting.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | request latched, counting down to the access
// RESP  | response held on rsp_* until rsp_ready
module core_dmem_responder #(
  parameter int XLEN    = 64,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int LANES = XLEN / 8;
  localparam int OFF   = $clog2(LANES);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt;
  logic             accept, access;

  logic             l_wen;
  logic [31:0]      l_addr;
  logic [1:0]       l_size;
  logic [XLEN-1:0]  l_wdata;
  logic [LANES-1:0] l_wmask;

  logic             a_wen;
  logic [31:0]      a_addr;
  logic [1:0]       a_size;
  logic [XLEN-1:0]  a_wdata;
  logic [LANES-1:0] a_wmask;
  logic [31:0]      a_idx;
  logic [AW-1:0]    a_row;
  logic             a_mis, a_err;

  logic [XLEN-1:0]  mem [DEPTH];

  // With LATENCY = 1 the access happens on the accept edge, so it must use the live request.
  always_comb begin
    if (state == IDLE) begin
      a_wen   = req_wen;
      a_addr  = req_addr;
      a_size  = req_size;
      a_wdata = req_wdata;
      a_wmask = req_wmask;
    end else begin
      a_wen   = l_wen;
      a_addr  = l_addr;
      a_size  = l_size;
      a_wdata = l_wdata;
      a_wmask = l_wmask;
    end
    a_idx = a_addr >> OFF;
    a_row = a_idx[AW-1:0];
    case (a_size)
      2'd0:    a_mis = 1'b0;
      2'd1:    a_mis = a_addr[0];
      2'd2:    a_mis = |a_addr[1:0];
      default: a_mis = |a_addr[2:0];
    endcase
    a_err = (a_idx >= 32'(DEPTH)) || a_mis;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        accept = 1'b1;
        if (LATENCY == 1) begin
          state_nxt = RESP;
          access    = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: if (cnt == 4'd0) begin
        state_nxt = RESP;
        access    = 1'b1;
      end
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      state_nxt = IDLE;
      accept    = 1'b0;
      access    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= CNT_INIT;
      else if (state == WAIT && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (access) begin
        rsp_err   <= a_err;
        rsp_rdata <= (a_wen || a_err) ? '0 : mem[a_row];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      l_wen   <= req_wen;
      l_addr  <= req_addr;
      l_size  <= req_size;
      l_wdata <= req_wdata;
      l_wmask <= req_wmask;
    end
  end

  // Memory is deliberately outside reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (access && a_wen && !a_err) begin
      for (int i = 0; i < LANES; i++)
        if (a_wmask[i]) mem[a_row][8*i +: 8] <= a_wdata[8*i +: 8];
    end
  end

  assign req_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_core_dmem_responder.sv
// Directed plus randomized bench for core_dmem_responder at LATENCY 2, 1 and 15,
// checked against a word-array reference model.
module tb_core_dmem_responder;
  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [ND];
  logic        req_valid [ND];
  logic        req_ready [ND];
  logic        req_wen   [ND];
  logic [31:0] req_addr  [ND];
  logic [1:0]  req_size  [ND];
  logic [63:0] req_wdata [ND];
  logic [7:0]  req_wmask [ND];
  logic        rsp_valid [ND];
  logic        rsp_ready [ND];
  logic [63:0] rsp_rdata [ND];
  logic        rsp_err   [ND];

  int exp_lat [ND] = '{2, 1, 15};

  core_dmem_responder #(.XLEN(64), .DEPTH(1024), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
    .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));
  core_dmem_responder #(.XLEN(64), .DEPTH(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
    .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));
  core_dmem_responder #(.XLEN(64), .DEPTH(1024), .LATENCY(15)) u_l15 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_wen(req_wen[2]), .req_addr(req_addr[2]), .req_size(req_size[2]),
    .req_wdata(req_wdata[2]), .req_wmask(req_wmask[2]), .rsp_valid(rsp_valid[2]),
    .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  logic [63:0] ref_mem [ND][1024];
  bit          known   [ND][1024];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input logic [31:0] addr, input logic [1:0] size);
    int unsigned idx;
    int unsigned align;
    idx   = addr / 8;
    align = 1 << size;
    return (idx >= 1024) || ((addr % align) != 0);
  endfunction

  // One full request/response; stall = cycles rsp_ready stays low, keep = hold req_valid meanwhile.
  task automatic txn(input int d, input bit wen, input logic [31:0] addr, input logic [1:0] size,
                     input logic [63:0] wdata, input logic [7:0] wmask,
                     input int stall, input bit keep);
    bit          e_err, chk_data, got;
    logic [63:0] e_rdata;
    int unsigned idx;
    int          n, lat;
    idx      = addr / 8;
    e_err    = model_err(addr, size);
    chk_data = 1'b1;
    e_rdata  = 64'd0;
    if (!wen && !e_err) begin
      if (known[d][idx]) e_rdata = ref_mem[d][idx];
      else chk_data = 1'b0;
    end
    @(negedge clk);
    req_wen[d] = wen; req_addr[d] = addr; req_size[d] = size;
    req_wdata[d] = wdata; req_wmask[d] = wmask; req_valid[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      check($sformatf("accept_timeout_d%0d", d), 64'(req_ready[d]), 64'd1);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      if (!keep) req_valid[d] = 1'b0;
      lat++;
      got = rsp_valid[d];
    end
    check($sformatf("latency_d%0d_a%h", d, addr), 64'(lat), 64'(exp_lat[d]));
    if (!got) begin
      req_valid[d] = 1'b0;
      return;
    end
    check($sformatf("err_d%0d_a%h", d, addr), 64'(rsp_err[d]), 64'(e_err));
    if (chk_data) check($sformatf("rdata_d%0d_a%h", d, addr), rsp_rdata[d], e_rdata);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check($sformatf("stall_valid_d%0d", d), 64'(rsp_valid[d]), 64'd1);
      check($sformatf("stall_ready_d%0d", d), 64'(req_ready[d]), 64'd0);
      check($sformatf("stall_err_d%0d", d), 64'(rsp_err[d]), 64'(e_err));
      if (chk_data) check($sformatf("stall_rdata_d%0d", d), rsp_rdata[d], e_rdata);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    check($sformatf("post_hs_valid_d%0d", d), 64'(rsp_valid[d]), 64'd0);
    check($sformatf("post_hs_ready_d%0d", d), 64'(req_ready[d]), 64'd1);
    req_valid[d] = 1'b0;
    if (wen && !e_err) begin
      for (int i = 0; i < 8; i++)
        if (wmask[i]) ref_mem[d][idx][8*i +: 8] = wdata[8*i +: 8];
      if (wmask == 8'hFF) known[d][idx] = 1'b1;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    int          nrand;
    for (int d = 0; d < ND; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_addr[d] = '0;
      req_size[d] = '0; req_wdata[d] = '0; req_wmask[d] = '0; rsp_ready[d] = 1'b0;
      for (int w = 0; w < 1024; w++) known[d][w] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("rst_req_ready_d%0d", d), 64'(req_ready[d]), 64'd0);
      check($sformatf("rst_rsp_valid_d%0d", d), 64'(rsp_valid[d]), 64'd0);
      check($sformatf("rst_rdata_d%0d", d), rsp_rdata[d], 64'd0);
      check($sformatf("rst_err_d%0d", d), 64'(rsp_err[d]), 64'd0);
      rst[d] = 1'b0;
    end
    @(negedge clk);
    check("idle_ready", 64'(req_ready[0]), 64'd1);

    // Store/load round trip and partial-lane overwrite.
    txn(0, 1'b1, 32'h10, 2'd3, 64'h1122334455667788, 8'hFF, 0, 1'b0);
    txn(0, 1'b0, 32'h10, 2'd3, 64'd0, 8'h00, 0, 1'b0);
    check("direct_0x10", ref_mem[0][2], 64'h1122334455667788);
    txn(0, 1'b1, 32'h10, 2'd3, 64'hAAAAAAAABBBBBBBB, 8'h0F, 0, 1'b0);
    txn(0, 1'b0, 32'h10, 2'd3, 64'd0, 8'h00, 0, 1'b0);
    check("direct_0x10_mask", ref_mem[0][2], 64'h11223344BBBBBBBB);

    // Faults: misaligned, out of range, faulting stores leave memory alone.
    txn(0, 1'b1, 32'h0, 2'd3, 64'hCAFEF00D12345678, 8'hFF, 0, 1'b0);
    txn(0, 1'b0, 32'h2002, 2'd2, 64'd0, 8'h00, 0, 1'b0);
    txn(0, 1'b0, 32'h2000, 2'd3, 64'd0, 8'h00, 0, 1'b0);
    txn(0, 1'b1, 32'h2000, 2'd3, 64'hDEADDEADDEADDEAD, 8'hFF, 0, 1'b0);
    txn(0, 1'b1, 32'h12, 2'd3, 64'hDEADDEADDEADDEAD, 8'hFF, 0, 1'b0);
    txn(0, 1'b0, 32'h0, 2'd3, 64'd0, 8'h00, 0, 1'b0);
    txn(0, 1'b0, 32'h10, 2'd3, 64'd0, 8'h00, 0, 1'b0);

    // Response backpressure with a competing request held high.
    txn(0, 1'b0, 32'h10, 2'd3, 64'd0, 8'h00, 5, 1'b1);

    // Reset while WAITing discards the store.
    txn(0, 1'b1, 32'h18, 2'd3, 64'h0123456789ABCDEF, 8'hFF, 0, 1'b0);
    @(negedge clk);
    check("pre_abort_ready", 64'(req_ready[0]), 64'd1);
    req_wen[0] = 1'b1; req_addr[0] = 32'h18; req_size[0] = 2'd3;
    req_wdata[0] = 64'h5555AAAA5555AAAA; req_wmask[0] = 8'hFF; req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_rst_valid", 64'(rsp_valid[0]), 64'd0);
      check("abort_rst_ready", 64'(req_ready[0]), 64'd0);
    end
    rst[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_after_valid", 64'(rsp_valid[0]), 64'd0);
    end
    txn(0, 1'b0, 32'h18, 2'd3, 64'd0, 8'h00, 0, 1'b0);

    // Randomized traffic on all three latencies over a small pre-written window.
    for (int d = 0; d < ND; d++) begin
      for (int k = 0; k < 8; k++)
        txn(d, 1'b1, 32'h100 + 32'(8*k), 2'd3, {$urandom, $urandom}, 8'hFF, 0, 1'b0);
      nrand = (d == 0) ? 40 : 12;
      for (int t = 0; t < nrand; t++) begin
        if ($urandom_range(0, 9) == 0) addr = 32'h2000 + 32'(8 * $urandom_range(0, 3));
        else addr = 32'h100 + 32'(8 * $urandom_range(0, 7));
        addr = addr + 32'($urandom_range(0, 7));
        txn(d, 1'($urandom_range(0, 1)), addr, 2'($urandom_range(0, 3)),
            {$urandom, $urandom}, 8'($urandom_range(0, 255)),
            int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/core_dmem_responder.md
CORE_DMEM_RESPONDER -- requirements
Module: core_dmem_responder

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning data width in bits (byte lanes = XLEN/8).
REQ-002 SHALL have parameter DEPTH, default 1024, meaning memory size in XLEN-wide words.
REQ-003 SHALL have parameter LATENCY, default 2, meaning cycles from request accept to response valid; legal range 1..15.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port req_valid, input, 1, initiator presents a request.
REQ-007 SHALL have port req_ready, output, 1, responder can accept a request.
REQ-008 SHALL have port req_wen, input, 1, 1 = store, 0 = load.
REQ-009 SHALL have port req_addr, input, 32, byte address.
REQ-010 SHALL have port req_size, input, 2, access size: 0 byte, 1 half, 2 word, 3 dword.
REQ-011 SHALL have port req_wdata, input, XLEN, store data, lane-aligned.
REQ-012 SHALL have port req_wmask, input, XLEN/8, store byte-lane enables.
REQ-013 SHALL have port rsp_valid, output, 1, response is valid.
REQ-014 SHALL have port rsp_ready, input, 1, initiator accepts the response.
REQ-015 SHALL have port rsp_rdata, output, XLEN, full aligned word read.
REQ-016 SHALL have port rsp_err, output, 1, access fault.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE and when rst = 0.
REQ-018 SHALL accept a request on a rising edge with req_valid & req_ready, and latch wen/addr/size/wdata/wmask.
REQ-019 SHALL, on accept, go to RESP if LATENCY = 1; otherwise go to WAIT with a 4-bit counter loaded with LATENCY-2.
REQ-020 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the cycle after the counter reads 0; rsp_valid SHALL rise exactly LATENCY cycles after the accept edge.
REQ-021 SHALL perform the memory access exactly once, on the edge entering RESP, using word index addr[31:3] (for XLEN = 64).
REQ-022 SHALL set err = 1 when word index >= DEPTH, or when addr mod 2^size != 0 (misaligned).
REQ-023 SHALL, on a store with err = 0, write only lanes with wmask = 1; on err = 1 no lane is written.
REQ-024 SHALL, on a load with err = 0, register the addressed word into rsp_rdata; load with err = 1, and every store, gives rsp_rdata = 0.
REQ-025 SHALL, in RESP, drive rsp_valid = 1 with rsp_rdata/rsp_err stable until rsp_ready = 1; on that handshake go to IDLE.
REQ-026 SHALL ignore req_valid outside IDLE; at most one outstanding request; next accept no earlier than the cycle after the response handshake.
REQ-027 SHALL make a load issued after a store handshake to the same word return the stored data (no stale read).
REQ-028 SHALL leave memory contents uninitialised; they are not cleared by rst.

Reset
REQ-029 SHALL, while rst = 1 at a clock edge, force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0; req_ready SHALL be 0 while rst = 1.
REQ-030 SHALL, on rst asserted in WAIT, discard the pending access (no write occurs); in RESP, drop the response.
REQ-031 SHALL preserve memory contents across rst.

Verification
REQ-032 Store addr 0x10, size 3, wdata 0x1122334455667788, wmask 0xFF, then load 0x10 -> rsp_valid exactly 2 cycles after each accept; load rdata 0x1122334455667788, err 0.
REQ-033 Store to 0x10 with wmask 0x0F, wdata 0xAAAAAAAABBBBBBBB after REQ-032 -> load 0x10 returns 0x11223344BBBBBBBB.
REQ-034 Load addr 0x2002 size 2 (misaligned) and load addr 0x2000 (index 1024 = DEPTH) -> each rsp_err 1, rdata 0; store to 0x2000 writes no memory.
REQ-035 Hold rsp_ready 0 for 5 cycles in RESP while req_valid = 1 -> rsp_valid/rdata stable, req_ready 0, no second accept; accept occurs the cycle after rsp_ready handshake.
REQ-036 Accept store to 0x18, assert rst one cycle later (in WAIT) -> rsp_valid never rises, req_ready 0 during reset, later load 0x18 returns its pre-store value.
REQ-037 Run with LATENCY = 1 and LATENCY = 15 -> rsp_valid 1 and 15 cycles after accept respectively.
